// File: rtl/rain_pkg.sv
// rain_pkg: definitions shared by the rain_meter slice.
//   conv_state_t  - BCD converter states (IDLE, SHIFT, DONE)
//   conv_dbg_t    - converter debug bundle exported by rain_meter
//   UNIT_FRAC_DIGITS - fractional BCD digits implied by the 0.01 mm unit
//   DEFAULT_PULSE_UMM - default rain depth per pulse, in 0.01 mm
//   add3()        - shift-add-3 digit correction
package rain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    typedef struct packed {
        conv_state_t state;
        logic        busy;
        logic        done;
        logic        pending;
    } conv_dbg_t;

    // Depth is carried in 0.01 mm units, so the two low BCD digits are fractional.
    localparam int UNIT_FRAC_DIGITS  = 2;
    localparam int DEFAULT_PULSE_UMM = 28;

    // A digit of 5 or more becomes >= 8 after +3, so the following left
    // shift carries it into the next decade.
    function automatic logic [3:0] add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request a conversion of bin (accepted only in IDLE)
//   bin        : binary value, snapshotted on acceptance
//   busy       : high from the cycle after acceptance until back in IDLE
//   done       : high for the single DONE cycle that loads bcd
//   bcd        : registered result, DIGITS digits, digit 0 in [3:0]
//   state      : converter state, for observation
// Handshake: start is a level request; it is taken on a clock edge where
// state is IDLE and start is high, and the caller drops it once busy rises.
// BIN_W iterations run in SHIFT, then DONE updates bcd for one cycle.
module bin2bcd_seq
    import rain_pkg::*;
#(
    parameter int BIN_W  = 17,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output conv_state_t           state
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    logic [BIN_W-1:0]    bin_sr;
    logic [4*DIGITS-1:0] bcd_sr;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [CNT_W-1:0]    iter;

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = add3(bcd_sr[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            bin_sr <= '0;
            bcd_sr <= '0;
            iter   <= '0;
            bcd    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr <= bin;
                        bcd_sr <= '0;
                        iter   <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The input is below 10**DIGITS, so nothing useful
                    // leaves the top of the BCD field.
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    if (iter == CNT_W'(BIN_W - 1)) begin
                        state <= DONE;
                    end else begin
                        iter <= iter + CNT_W'(1);
                    end
                end
                DONE: begin
                    bcd   <= bcd_sr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: rtl/rain_meter.sv
// rain_meter: debounced rain pulse counter with scaled BCD total and rate window.
//   Clock             : system clock, posedge
//   nReset            : asynchronous reset, active-low
//   nStart            : synchronous clear of totals, active-low
//   nRain             : raw sensor pulse, active-low, asynchronous
//   SecondTick        : one-cycle 1 Hz strobe
//   total_rain_pulses : accepted pulses, saturating
//   count_overflow    : sticky, set by a pulse while the count is saturated
//   rain_bcd          : total * PULSE_UMM in BCD (0.01 mm), clamped to all nines
//   bcd_valid         : rain_bcd matches the current total
//   rate_pulses       : pulses in the last completed RATE_TICKS window
//   conv_dbg          : converter state, busy/done and pending flag
module rain_meter
    import rain_pkg::*;
#(
    parameter int PULSE_UMM       = DEFAULT_PULSE_UMM,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_W         = 16,
    parameter int DIGITS          = 5,
    parameter int RATE_TICKS      = 3600
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic                nStart,
    input  logic                nRain,
    input  logic                SecondTick,
    output logic [COUNT_W-1:0]  total_rain_pulses,
    output logic                count_overflow,
    output logic [4*DIGITS-1:0] rain_bcd,
    output logic                bcd_valid,
    output logic [COUNT_W-1:0]  rate_pulses,
    output conv_dbg_t           conv_dbg
);

    localparam int          BIN_W   = $clog2(10**DIGITS);
    localparam int unsigned MAX_VAL = 10**DIGITS - 1;
    localparam int          DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int          TICK_W  = $clog2(RATE_TICKS + 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    if (DEBOUNCE_CYCLES < 1 || DIGITS <= UNIT_FRAC_DIGITS) begin : g_bad_params
        $error("rain_meter: DEBOUNCE_CYCLES must be >= 1 and DIGITS must exceed the fractional digits");
    end

    // ---------------- input conditioning ----------------
    logic            sync_1;
    logic            s;
    logic            f;
    logic            f_d;
    logic [DB_W-1:0] db_cnt;
    logic            fall;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync_1 <= 1'b1;
            s      <= 1'b1;
            f      <= 1'b1;
            f_d    <= 1'b1;
            db_cnt <= '0;
        end else begin
            sync_1 <= nRain;
            s      <= sync_1;
            f_d    <= f;
            if (s == f) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                f      <= s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign fall = f_d & ~f;

    // ---------------- counters and rate window ----------------
    logic [COUNT_W-1:0] win_count;
    logic [TICK_W-1:0]  win_ticks;
    logic               window_close;
    logic               count_change;

    assign window_close = SecondTick && (win_ticks == TICK_W'(RATE_TICKS - 1));
    assign count_change = nStart && fall && (total_rain_pulses != CNT_MAX);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            total_rain_pulses <= '0;
            count_overflow    <= 1'b0;
            win_count         <= '0;
            win_ticks         <= '0;
            rate_pulses       <= '0;
        end else if (!nStart) begin
            // Clear wins over a coincident pulse; the last rate stays visible.
            total_rain_pulses <= '0;
            count_overflow    <= 1'b0;
            win_count         <= '0;
            win_ticks         <= '0;
        end else begin
            if (fall) begin
                if (total_rain_pulses == CNT_MAX) begin
                    count_overflow <= 1'b1;
                end else begin
                    total_rain_pulses <= total_rain_pulses + COUNT_W'(1);
                end
            end
            if (window_close) begin
                // A pulse on the closing tick opens the next window.
                rate_pulses <= win_count;
                win_count   <= {{(COUNT_W-1){1'b0}}, fall};
                win_ticks   <= '0;
            end else begin
                if (SecondTick) begin
                    win_ticks <= win_ticks + TICK_W'(1);
                end
                if (fall && win_count != CNT_MAX) begin
                    win_count <= win_count + COUNT_W'(1);
                end
            end
        end
    end

    // ---------------- scaling and conversion ----------------
    logic [63:0]         product;
    logic [BIN_W-1:0]    value;
    logic                pending;
    logic                conv_busy;
    logic                conv_done;
    conv_state_t         conv_state;

    assign product = 64'(total_rain_pulses) * 64'(PULSE_UMM);
    assign value   = (product > 64'(MAX_VAL)) ? BIN_W'(MAX_VAL) : product[BIN_W-1:0];

    // pending is cleared on the edge the idle converter accepts it; a count
    // change on that same edge re-arms it so a fresh conversion follows.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pending <= 1'b0;
        end else if (!nStart || count_change) begin
            pending <= 1'b1;
        end else if (!conv_busy) begin
            pending <= 1'b0;
        end
    end

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk    (Clock),
        .rst_n  (nReset),
        .start  (pending),
        .bin    (value),
        .busy   (conv_busy),
        .done   (conv_done),
        .bcd    (rain_bcd),
        .state  (conv_state)
    );

    assign bcd_valid = !conv_busy && !pending;

    always_comb begin
        conv_dbg.state   = conv_state;
        conv_dbg.busy    = conv_busy;
        conv_dbg.done    = conv_done;
        conv_dbg.pending = pending;
    end

endmodule

// File: tb/tb_rain_meter.sv
`timescale 1ns/1ps
module tb_rain_meter;
    import rain_pkg::*;

    localparam int D     = 4;
    localparam int BIN_W = 17;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_reset;

    // dut_a: default parameters
    logic        nstart_a;
    logic        nrain_a;
    logic        tick_a;
    logic [15:0] total_a;
    logic        ovf_a;
    logic [19:0] bcd_a;
    logic        valid_a;
    logic [15:0] rate_a;
    conv_dbg_t   dbg_a;

    // dut_b: 4-bit counters, 10-tick rate window
    logic        nstart_b;
    logic        nrain_b;
    logic        tick_b;
    logic [3:0]  total_b;
    logic        ovf_b;
    logic [19:0] bcd_b;
    logic        valid_b;
    logic [3:0]  rate_b;
    conv_dbg_t   dbg_b;

    rain_meter dut_a (
        .Clock             (clk),
        .nReset            (n_reset),
        .nStart            (nstart_a),
        .nRain             (nrain_a),
        .SecondTick        (tick_a),
        .total_rain_pulses (total_a),
        .count_overflow    (ovf_a),
        .rain_bcd          (bcd_a),
        .bcd_valid         (valid_a),
        .rate_pulses       (rate_a),
        .conv_dbg          (dbg_a)
    );

    rain_meter #(
        .COUNT_W    (4),
        .RATE_TICKS (10)
    ) dut_b (
        .Clock             (clk),
        .nReset            (n_reset),
        .nStart            (nstart_b),
        .nRain             (nrain_b),
        .SecondTick        (tick_b),
        .total_rain_pulses (total_b),
        .count_overflow    (ovf_b),
        .rain_bcd          (bcd_b),
        .bcd_valid         (valid_b),
        .rate_pulses       (rate_b),
        .conv_dbg          (dbg_b)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int get_count(input bit sel);
        return sel ? int'(total_b) : int'(total_a);
    endfunction

    function automatic logic [19:0] get_bcd(input bit sel);
        return sel ? bcd_b : bcd_a;
    endfunction

    function automatic logic get_ovf(input bit sel);
        return sel ? ovf_b : ovf_a;
    endfunction

    function automatic logic get_valid(input bit sel);
        return sel ? valid_b : valid_a;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_rain(input bit sel, input logic v);
        if (sel) nrain_b = v;
        else     nrain_a = v;
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) nstart_b = v;
        else     nstart_a = v;
    endtask

    // One clean pulse: low for D+1 edges, high for at least D+1 edges.
    task automatic pulse(input bit sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_rain(sel, 1'b0);
            repeat (D + 1) @(negedge clk);
            set_rain(sel, 1'b1);
            repeat (D + 1) @(negedge clk);
        end
    endtask

    task automatic clear(input bit sel);
        @(negedge clk);
        set_start(sel, 1'b0);
        @(negedge clk);
        set_start(sel, 1'b1);
    endtask

    task automatic wait_settled(input bit sel, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (get_valid(sel) !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (get_valid(sel) !== 1'b1) begin
            n_checks++;
            n_bad++;
            $display("FAIL %s: bcd_valid still %b after %0d cycles, expected 1", name, get_valid(sel), k);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick_b = 1'b1;
            @(negedge clk);
            tick_b = 1'b0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          sel;
        bit          clr;
        int          pulses;
        int          exp_count;
        logic [19:0] exp_bcd;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{sel: 1'b0, clr: 1'b0, pulses: 1,    exp_count: 1,    exp_bcd: 20'h00028, exp_ovf: 1'b0};
        vecs[1] = '{sel: 1'b0, clr: 1'b0, pulses: 356,  exp_count: 357,  exp_bcd: 20'h09996, exp_ovf: 1'b0};
        vecs[2] = '{sel: 1'b0, clr: 1'b0, pulses: 3215, exp_count: 3572, exp_bcd: 20'h99999, exp_ovf: 1'b0};
        vecs[3] = '{sel: 1'b0, clr: 1'b1, pulses: 0,    exp_count: 0,    exp_bcd: 20'h00000, exp_ovf: 1'b0};
        vecs[4] = '{sel: 1'b0, clr: 1'b0, pulses: 5,    exp_count: 5,    exp_bcd: 20'h00140, exp_ovf: 1'b0};
        vecs[5] = '{sel: 1'b1, clr: 1'b0, pulses: 20,   exp_count: 15,   exp_bcd: 20'h00420, exp_ovf: 1'b1};
        vecs[6] = '{sel: 1'b1, clr: 1'b1, pulses: 0,    exp_count: 0,    exp_bcd: 20'h00000, exp_ovf: 1'b0};

        n_reset  = 1'b0;
        nstart_a = 1'b1;
        nrain_a  = 1'b1;
        tick_a   = 1'b0;
        nstart_b = 1'b1;
        nrain_b  = 1'b1;
        tick_b   = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_count_a", total_a, 0);
        check("rst_ovf_a",   ovf_a,   0);
        check("rst_bcd_a",   bcd_a,   0);
        check("rst_valid_a", valid_a, 1);
        check("rst_rate_a",  rate_a,  0);
        check("rst_state_a", 32'(dbg_a.state), 32'(IDLE));
        check("rst_count_b", total_b, 0);
        check("rst_valid_b", valid_b, 1);
        check("rst_state_b", 32'(dbg_b.state), 32'(IDLE));
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].clr) clear(vecs[i].sel);
            pulse(vecs[i].sel, vecs[i].pulses);
            wait_settled(vecs[i].sel, $sformatf("v%0d_settle", i));
            check($sformatf("v%0d_count", i), get_count(vecs[i].sel), vecs[i].exp_count);
            check($sformatf("v%0d_bcd", i),   get_bcd(vecs[i].sel),   vecs[i].exp_bcd);
            check($sformatf("v%0d_ovf", i),   get_ovf(vecs[i].sel),   vecs[i].exp_ovf);
        end

        // ---------------- latency of count and conversion (A at 5) ----------------
        @(negedge clk);
        nrain_a = 1'b0;
        repeat (6) @(negedge clk);
        check("lat_before_count", total_a, 5);
        @(negedge clk);
        check("lat_count",       total_a, 6);
        check("lat_valid_low",   valid_a, 0);
        nrain_a = 1'b1;
        repeat (BIN_W + 1) @(negedge clk);
        check("lat_bcd_before",  bcd_a,   20'h00140);
        check("lat_valid_still", valid_a, 0);
        @(negedge clk);
        check("lat_bcd_after",   bcd_a,   20'h00168);
        check("lat_valid_high",  valid_a, 1);

        // ---------------- glitch filtering ----------------
        @(negedge clk);
        nrain_a = 1'b0;
        repeat (D - 1) @(negedge clk);
        nrain_a = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_short", total_a, 6);
        check("glitch_short_valid", valid_a, 1);
        @(negedge clk);
        nrain_a = 1'b0;
        repeat (D) @(negedge clk);
        nrain_a = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_exact", total_a, 7);
        wait_settled(1'b0, "glitch_settle");
        check("glitch_exact_bcd", bcd_a, 20'h00196);

        // ---------------- clear coincident with an accepted pulse ----------------
        @(negedge clk);
        nrain_a = 1'b0;
        repeat (6) @(negedge clk);
        nstart_a = 1'b0;
        @(negedge clk);
        nstart_a = 1'b1;
        check("clr_pulse_count", total_a, 0);
        nrain_a = 1'b1;
        repeat (12) @(negedge clk);
        check("clr_pulse_after", total_a, 0);
        wait_settled(1'b0, "clr_settle");
        check("clr_pulse_bcd", bcd_a, 20'h00000);

        // ---------------- pulse during SHIFT re-runs the conversion ----------------
        @(negedge clk);
        nrain_a = 1'b0;
        repeat (7) @(negedge clk);
        check("shift_first_count", total_a, 1);
        nrain_a = 1'b1;
        repeat (6) @(negedge clk);
        nrain_a = 1'b0;
        repeat (D + 1) @(negedge clk);
        nrain_a = 1'b1;
        check("shift_state", 32'(dbg_a.state), 32'(SHIFT));
        repeat (8) @(negedge clk);
        check("shift_count2",    total_a, 2);
        check("shift_first_bcd", bcd_a,   20'h00028);
        check("shift_pending",   valid_a, 0);
        wait_settled(1'b0, "shift_settle");
        check("shift_final_bcd", bcd_a, 20'h00056);

        // ---------------- rate window on dut_b ----------------
        pulse(1'b1, 3);
        check("rate_pre_count", total_b, 3);
        tick(9);
        check("rate_before_close", rate_b, 0);
        @(negedge clk);
        nrain_b = 1'b0;
        repeat (5) @(negedge clk);
        @(negedge clk);
        tick_b = 1'b1;
        @(negedge clk);
        tick_b = 1'b0;
        nrain_b = 1'b1;
        check("rate_close",       rate_b,  3);
        check("rate_close_count", total_b, 4);
        tick(10);
        check("rate_next_window", rate_b, 1);
        clear(1'b1);
        check("rate_kept_on_clear", rate_b,  1);
        check("rate_clear_count",   total_b, 0);

        // ---------------- reset during conversion ----------------
        pulse(1'b0, 1);
        check("mid_count", total_a, 3);
        check("mid_state", 32'(dbg_a.state), 32'(SHIFT));
        n_reset = 1'b0;
        #1;
        check("mid_rst_count", total_a, 0);
        check("mid_rst_bcd",   bcd_a,   0);
        check("mid_rst_valid", valid_a, 1);
        check("mid_rst_state", 32'(dbg_a.state), 32'(IDLE));
        check("mid_rst_rate_b", rate_b, 0);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/rain_meter.md
# rain_meter

Parametrised successor to the single-channel rain gauge, sitting between the rain sensor pad and the display driver. It debounces the raw nRain input, counts pulses with saturation and a sticky overflow flag, and scales the count by a configurable depth-per-pulse. It converts the scaled total to BCD with a sequential shift-add-3 engine instead of combinational division, and latches a rainfall-rate count over a configurable window of SecondTick strobes.

## Interface
- PULSE_UMM, 28: rain depth per pulse, in 0.01 mm units.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept an nRain level change; must be ≥1.
- COUNT_W, 16: width of the pulse counters.
- DIGITS, 5: BCD digit count. The two least-significant digits are fractional (ddd.dd for 5).
- RATE_TICKS, 3600: number of SecondTick strobes per rate window.
- BIN_W, derived: $clog2(10**DIGITS). This is the scaled-value width.
- Clock  input  1  system clock; all logic is on posedge.
- nReset  input  1  asynchronous reset, active-low.
- nStart  input  1  Start/Adjust button, active-low. Synchronous clear of totals.
- nRain  input  1  raw sensor pulse, active-low, asynchronous to Clock.
- SecondTick  input  1  one-cycle 1 Hz strobe.
- total_rain_pulses  output  COUNT_W  accepted pulse count, saturating.
- count_overflow  output  1  sticky flag; high once a pulse arrives while the count is at its maximum.
- rain_bcd  output  4*DIGITS  scaled total as BCD; digit 0 (0.01 mm) is in [3:0].
- bcd_valid  output  1  high when rain_bcd reflects the current total_rain_pulses.
- rate_pulses  output  COUNT_W  pulses counted in the last completed window.

## Operation
- **Input conditioning**
  - nRain passes through a 2-flop synchroniser to give the synced signal s.
  - The filtered level f starts at 1. f takes the value of s after s has differed from f for DEBOUNCE_CYCLES consecutive cycles; any return to f restarts the stable counter.
  - An accepted pulse is a 1→0 transition of f.
- **Counting**
  - On each accepted pulse, total_rain_pulses increments and saturates at 2^COUNT_W−1.
  - A pulse that arrives while the count is saturated sets count_overflow.
- **nStart low (sampled synchronously)**
  - Clears total_rain_pulses, count_overflow, the window pulse count and the window tick count.
  - rate_pulses is not cleared.
  - A pulse coincident with nStart low is dropped; clear wins.
- **Scaling**
  - value = total_rain_pulses × PULSE_UMM, computed at full product width.
  - value saturates to 10^DIGITS−1 (999.99 for 5 digits) before conversion.
- **Converter FSM** (states IDLE, SHIFT, DONE)
  - IDLE→SHIFT when the pending flag is set. On that transition, value is snapshotted and the pending flag is cleared.
  - SHIFT runs BIN_W shift-add-3 iterations, one per cycle.
  - DONE lasts one cycle: it loads rain_bcd and then returns to IDLE.
  - The pending flag is set whenever total_rain_pulses changes, and on nStart.
  - A count change during SHIFT is not applied to the running conversion; it re-sets pending and triggers a fresh conversion after DONE.
  - bcd_valid = (state==IDLE) && !pending.
- **Rate window**
  - The window pulse count saturates like the main counter.
  - On the RATE_TICKS-th SecondTick, rate_pulses is loaded from the window count, which then restarts at 0.
  - If a pulse lands on the same cycle as the closing tick, it counts into the new window.

## Timing
- Reset values:
  - total_rain_pulses=0, count_overflow=0, rain_bcd=0, bcd_valid=1, rate_pulses=0.
  - f=1, FSM in IDLE, pending=0.
- nRain fall to count increment: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the first sampling edge.
- Count change to bcd_valid low: the next cycle.
- rain_bcd update: BIN_W+2 cycles after the count change, if the FSM was idle. bcd_valid returns high on the cycle after DONE.
- Conversion of a saturated value completes in the same latency.
- Asserting nReset mid-conversion aborts to IDLE immediately; all outputs take their reset values.

## Structure
- Shared package rain_pkg:
  - converter state enum (IDLE/SHIFT/DONE);
  - the 0.01 mm unit constant;
  - the default PULSE_UMM.
- One sub-module, bin2bcd_seq, parametrised by BIN_W and DIGITS. Ports: start, bin, busy, done, bcd.
- Debounce, counters and the rate window stay in rain_meter.

## Test plan
- 1 clean pulse with defaults → total_rain_pulses=1; rain_bcd=0x00028 after BIN_W+2 cycles; bcd_valid low then high.
- 357 pulses → rain_bcd=0x09996 (099.96); 3572 pulses → count 3572, rain_bcd=0x99999 (saturated display).
- nRain glitch low for DEBOUNCE_CYCLES−1 cycles → no increment. Glitch for DEBOUNCE_CYCLES cycles → +1.
- COUNT_W=4, 20 pulses → total_rain_pulses=15, count_overflow=1. Then nStart low for 1 cycle → 0, 0, and rain_bcd=0 after conversion.
- RATE_TICKS=10, 3 pulses inside the window → rate_pulses=3 on the cycle after the 10th tick. A pulse on the closing tick counts toward the next window.
- nStart low on the same cycle as an accepted pulse → count 0. A pulse during SHIFT → a second conversion, with the final rain_bcd matching the final count.
